// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl -- pipeline-side initiator for the RV32M multiply/divide unit.
//
// Takes one M-extension instruction from execute and stalls the pipeline
// while the M unit works. It drives START/M_CNT/RS1/RS2 to the unit and
// holds them stable until READY. It then hands the result to writeback as a
// one-cycle tagged strobe. A flush kills the in-flight op. A busy watchdog
// frees the pipeline if the unit never answers and raises a sticky error.
//
// Optional feature (macro M_FASTPATH_EN):
//   When defined, division by zero and signed division overflow are resolved
//   here without involving the M unit. The op goes straight IDLE -> DONE.
//   When undefined, every op goes through the M unit.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ex_valid     execute stage holds a valid instruction
//   i_ex_is_m      instruction is RV32M
//   i_ex_m_cnt     funct3 (0 mul,1 mulh,2 mulhsu,3 mulhu,4 div,5 divu,6 rem,7 remu)
//   i_ex_rs1/rs2   operands
//   i_ex_rd        destination tag
//   i_flush        kill in-flight M instruction
//   o_stall_pipe   freeze pipeline (combinational)
//   o_m_start      request to M unit (registered)
//   o_m_cnt        op to M unit (registered)
//   o_m_rs1/rs2    operands to M unit (registered)
//   i_m_out        result from M unit
//   i_m_ready      M unit result valid
//   o_wb_valid     one-cycle writeback strobe
//   o_wb_rd        writeback tag
//   o_wb_data      writeback data
//   o_m_err        sticky watchdog error, cleared only by reset
//   o_stall_cnt    saturating count of cycles spent in BUSY
module m_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_m,
  input  logic [2:0]       i_ex_m_cnt,
  input  logic [XLEN-1:0]  i_ex_rs1,
  input  logic [XLEN-1:0]  i_ex_rs2,
  input  logic [RD_W-1:0]  i_ex_rd,
  input  logic             i_flush,
  output logic             o_stall_pipe,
  output logic             o_m_start,
  output logic [2:0]       o_m_cnt,
  output logic [XLEN-1:0]  o_m_rs1,
  output logic [XLEN-1:0]  o_m_rs2,
  input  logic [XLEN-1:0]  i_m_out,
  input  logic             i_m_ready,
  output logic             o_wb_valid,
  output logic [RD_W-1:0]  o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  output logic             o_m_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  logic              r_m_start;
  logic [2:0]        r_m_cnt;
  logic [XLEN-1:0]   r_m_rs1;
  logic [XLEN-1:0]   r_m_rs2;
  logic [RD_W-1:0]   r_tag;
  logic [RD_W-1:0]   r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_m_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [TMR_W-1:0]  r_timer;

  logic              w_req;

  // A request exists only when execute presents an unflushed M instruction.
  assign w_req = i_ex_valid & i_ex_is_m & ~i_flush;

`ifdef M_FASTPATH_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_fast;
  logic [XLEN-1:0] w_fast_data;
  logic            w_rs2_zero;
  logic            w_ovf;

  // Spot the division corner cases that have architecturally fixed results.
  // Bit 2 of funct3 marks div/rem, bit 1 marks rem, bit 0 marks unsigned.
  always_comb begin
    w_rs2_zero  = (i_ex_rs2 == '0);
    w_ovf       = (i_ex_rs1 == SMIN) && (&i_ex_rs2) && !i_ex_m_cnt[0];
    w_fast      = i_ex_m_cnt[2] & (w_rs2_zero | w_ovf);
    w_fast_data = '0;
    if (w_rs2_zero) begin
      w_fast_data = i_ex_m_cnt[1] ? i_ex_rs1 : '1;
    end else if (w_ovf) begin
      w_fast_data = i_ex_m_cnt[1] ? '0 : SMIN;
    end
  end
`endif

  // Main control FSM. The request to the M unit is held frozen throughout
  // BUSY because the unit restarts on any change. Flush beats READY. The
  // watchdog releases the pipeline with zero data and a sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_m_start   <= 1'b0;
      r_m_cnt     <= '0;
      r_m_rs1     <= '0;
      r_m_rs2     <= '0;
      r_tag       <= '0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_m_err     <= 1'b0;
      r_stall_cnt <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
`ifdef M_FASTPATH_EN
            if (w_fast) begin
              r_wb_data <= w_fast_data;
              r_wb_rd   <= i_ex_rd;
              r_state   <= S_DONE;
            end else begin
`endif
              r_m_cnt   <= i_ex_m_cnt;
              r_m_rs1   <= i_ex_rs1;
              r_m_rs2   <= i_ex_rs2;
              r_tag     <= i_ex_rd;
              r_m_start <= 1'b1;
              r_timer   <= '0;
              r_state   <= S_BUSY;
`ifdef M_FASTPATH_EN
            end
`endif
          end
        end
        S_BUSY: begin
          if (!(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
          if (i_flush) begin
            r_m_start <= 1'b0;
            r_state   <= S_IDLE;
          end else if (i_m_ready) begin
            r_wb_data <= i_m_out;
            r_wb_rd   <= r_tag;
            r_m_start <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_timer == TMR_LAST) begin
            r_m_err   <= 1'b1;
            r_m_start <= 1'b0;
            r_wb_data <= '0;
            r_wb_rd   <= r_tag;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The stall must assert in the same cycle the request is seen, so it is
  // decoded combinationally. DONE drops it so the instruction retires.
  assign o_stall_pipe = ((r_state == S_IDLE) & w_req) | (r_state == S_BUSY);
  assign o_wb_valid   = (r_state == S_DONE) & ~i_flush;

  assign o_m_start   = r_m_start;
  assign o_m_cnt     = r_m_cnt;
  assign o_m_rs1     = r_m_rs1;
  assign o_m_rs2     = r_m_rs2;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;
  assign o_m_err     = r_m_err;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Testbench for m_issue_ctrl.
// Runs a table of directed vectors, a few hand-written corner sequences and
// randomized ops checked against a transaction-level reference model. The
// stall counter is built narrow so that saturation is reachable.
// Define M_FASTPATH_EN to also exercise the division fast path.
module tb_m_issue_ctrl;

  localparam int XLEN    = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             exValid = 1'b0;
  logic             exIsM = 1'b0;
  logic [2:0]       exMCnt = '0;
  logic [XLEN-1:0]  exRs1 = '0;
  logic [XLEN-1:0]  exRs2 = '0;
  logic [RD_W-1:0]  exRd = '0;
  logic             flush = 1'b0;
  logic             stallPipe;
  logic             mStart;
  logic [2:0]       mCnt;
  logic [XLEN-1:0]  mRs1;
  logic [XLEN-1:0]  mRs2;
  logic [XLEN-1:0]  mOut = '0;
  logic             mReady = 1'b0;
  logic             wbValid;
  logic [RD_W-1:0]  wbRd;
  logic [XLEN-1:0]  wbData;
  logic             mErr;
  logic [CNT_W-1:0] stallCnt;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int modelStall     = 0;
  bit modelErr       = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          delay;
    int          flushAt;
    bit          flushDone;
    bit          expWb;
    logic [31:0] expData;
    int          expBusy;
    bit          expTimeout;
  } vec_t;

  vec_t vecs[13];

  m_issue_ctrl #(
    .XLEN(XLEN), .RD_W(RD_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_ex_valid(exValid), .i_ex_is_m(exIsM), .i_ex_m_cnt(exMCnt),
    .i_ex_rs1(exRs1), .i_ex_rs2(exRs2), .i_ex_rd(exRd),
    .i_flush(flush), .o_stall_pipe(stallPipe),
    .o_m_start(mStart), .o_m_cnt(mCnt), .o_m_rs1(mRs1), .o_m_rs2(mRs2),
    .i_m_out(mOut), .i_m_ready(mReady),
    .o_wb_valid(wbValid), .o_wb_rd(wbRd), .o_wb_data(wbData),
    .o_m_err(mErr), .o_stall_cnt(stallCnt)
  );

  always #5 clk = ~clk;

  // Architectural RV32M result, used both as the M unit's answer and as the
  // expected writeback data.
  function automatic logic [31:0] rv32m(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, pss, psu, puu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    pss = sa * sb;
    psu = sa * ub;
    puu = ua * ub;
    case (op)
      3'd0: return puu[31:0];
      3'd1: return pss[63:32];
      3'd2: return psu[63:32];
      3'd3: return puu[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  // One complete transaction, entered and left just after a rising edge with
  // the DUT idle. The busy length comes from the vector; the M unit answers
  // when the bench's schedule says so.
  task automatic applyStimulus(input vec_t v);
    int total;
    exValid = 1'b1; exIsM = 1'b1; exMCnt = v.op;
    exRs1 = v.rs1; exRs2 = v.rs2; exRd = v.rd;
    flush = 1'b0; mReady = 1'b0;
    @(negedge clk);
    checkBit("issue_wb_valid", wbValid, 1'b0);
    checkBit("issue_m_start", mStart, 1'b0);
    checkBit("issue_stall_pipe", stallPipe, 1'b1);
    checkOutput("stall_cnt", 32'(stallCnt), 32'(modelStall));
    checkBit("m_err", mErr, modelErr);
    @(posedge clk); #1;
    exValid = 1'b0;
    exRs1 = $urandom; exRs2 = $urandom; exMCnt = 3'($urandom); exRd = 5'($urandom);
    for (int k = 0; k < v.expBusy; k++) begin
      mReady = (k == v.delay);
      flush  = (k == v.flushAt);
      mOut   = mReady ? rv32m(mCnt, mRs1, mRs2) : $urandom;
      @(negedge clk);
      checkBit("busy_m_start", mStart, 1'b1);
      checkOutput("busy_m_cnt", 32'(mCnt), 32'(v.op));
      checkOutput("busy_m_rs1", mRs1, v.rs1);
      checkOutput("busy_m_rs2", mRs2, v.rs2);
      checkBit("busy_stall_pipe", stallPipe, 1'b1);
      checkBit("busy_wb_valid", wbValid, 1'b0);
      @(posedge clk); #1;
      mReady = 1'b0;
      flush  = 1'b0;
    end
    total = modelStall + v.expBusy;
    modelStall = (total > CNT_MAX) ? CNT_MAX : total;
    if (v.expTimeout) modelErr = 1'b1;
    if (v.flushAt >= 0) begin
      @(negedge clk);
      checkBit("flushed_m_start", mStart, 1'b0);
      checkBit("flushed_stall_pipe", stallPipe, 1'b0);
      checkBit("flushed_wb_valid", wbValid, 1'b0);
    end else begin
      flush = v.flushDone;
      @(negedge clk);
      checkBit("done_wb_valid", wbValid, v.expWb);
      checkBit("done_m_start", mStart, 1'b0);
      checkBit("done_stall_pipe", stallPipe, 1'b0);
      checkBit("done_m_err", mErr, modelErr);
      if (v.expWb) checkOutput("done_wb_data", wbData, v.expData);
      if (v.expWb && !v.expTimeout) checkOutput("done_wb_rd", 32'(wbRd), 32'(v.rd));
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

`ifdef M_FASTPATH_EN
  task automatic applyFast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] expData);
    exValid = 1'b1; exIsM = 1'b1; exMCnt = op; exRs1 = a; exRs2 = b; exRd = rd;
    @(negedge clk);
    checkBit("fast_issue_stall", stallPipe, 1'b1);
    @(posedge clk); #1;
    exValid = 1'b0;
    @(negedge clk);
    checkBit("fast_wb_valid", wbValid, 1'b1);
    checkOutput("fast_wb_data", wbData, expData);
    checkOutput("fast_wb_rd", 32'(wbRd), 32'(rd));
    checkBit("fast_m_start", mStart, 1'b0);
    checkOutput("fast_stall_cnt", 32'(stallCnt), 32'(modelStall));
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    vecs[0]  = '{3'd0, 32'd7, 32'd6, 5'd3, 4, -1, 1'b0, 1'b1, 32'd42, 5, 1'b0};
    vecs[1]  = '{3'd5, 32'd100, 32'd7, 5'd9, 6, 1, 1'b0, 1'b0, 32'd0, 2, 1'b0};
    vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, -1, 1'b0, 1'b1, 32'h4000_0000, 1, 1'b0};
    vecs[3]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5'd5, 2, -1, 1'b0, 1'b1, 32'h0, 3, 1'b0};
    vecs[4]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1, -1, 1'b0, 1'b1, 32'hFFFF_FFFE, 2, 1'b0};
    vecs[5]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 5'd1, 3, -1, 1'b0, 1'b1, 32'hFFFF_FFFF, 4, 1'b0};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, -1, 1'b0, 1'b1, 32'hFFFF_FFFD, 1, 1'b0};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 5, -1, 1'b0, 1'b1, 32'hFFFF_FFFF, 6, 1'b0};
    vecs[8]  = '{3'd7, 32'd100, 32'd7, 5'd10, 2, -1, 1'b1, 1'b0, 32'd2, 3, 1'b0};
    vecs[9]  = '{3'd4, 32'd100, 32'd7, 5'd14, 3, 3, 1'b0, 1'b0, 32'd0, 4, 1'b0};
    vecs[10] = '{3'd0, 32'd11, 32'd13, 5'd15, 5, 0, 1'b0, 1'b0, 32'd0, 1, 1'b0};
    vecs[11] = '{3'd0, 32'd123, 32'd456, 5'd12, -1, -1, 1'b0, 1'b1, 32'd0, 64, 1'b1};
    vecs[12] = '{3'd0, 32'd3, 32'd5, 5'd13, 1, -1, 1'b0, 1'b1, 32'd15, 2, 1'b0};

    #2;
    checkBit("reset_m_start", mStart, 1'b0);
    checkBit("reset_stall_pipe", stallPipe, 1'b0);
    checkBit("reset_wb_valid", wbValid, 1'b0);
    checkBit("reset_m_err", mErr, 1'b0);
    checkOutput("reset_stall_cnt", 32'(stallCnt), 32'd0);
    checkOutput("reset_wb_data", wbData, 32'd0);
    checkOutput("reset_m_rs1", mRs1, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Request gating in IDLE: non-M instructions and flushed ones never stall.
    exValid = 1'b1; exIsM = 1'b0;
    #1 checkBit("non_m_stall", stallPipe, 1'b0);
    exIsM = 1'b1; flush = 1'b1;
    #1 checkBit("flushed_req_stall", stallPipe, 1'b0);
    @(posedge clk); #1;
    checkBit("flushed_req_start", mStart, 1'b0);
    exValid = 1'b0; flush = 1'b0;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of BUSY clears everything at once.
    exValid = 1'b1; exIsM = 1'b1; exMCnt = 3'd0; exRs1 = 32'd9; exRs2 = 32'd9; exRd = 5'd2;
    @(posedge clk); #1;
    exValid = 1'b0;
    @(posedge clk); #3;
    rstN = 1'b0;
    #1;
    checkBit("async_m_start", mStart, 1'b0);
    checkOutput("async_m_rs1", mRs1, 32'd0);
    checkOutput("async_m_rs2", mRs2, 32'd0);
    checkOutput("async_m_cnt", 32'(mCnt), 32'd0);
    checkBit("async_stall_pipe", stallPipe, 1'b0);
    checkOutput("async_stall_cnt", 32'(stallCnt), 32'd0);
    checkBit("async_m_err", mErr, 1'b0);
    checkOutput("async_wb_data", wbData, 32'd0);
    checkOutput("async_wb_rd", 32'(wbRd), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    modelStall = 0;
    modelErr   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("post_reset_idle", mStart, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      rv.op  = 3'($urandom);
      rv.rs1 = $urandom;
      rv.rs2 = $urandom;
      if (rv.rs2 == 32'd0) rv.rs2 = 32'd1;
      if (rv.rs1 == SMIN) rv.rs1 = 32'd1;
      rv.rd        = 5'($urandom);
      rv.delay     = int'($urandom_range(0, 8));
      rv.flushAt   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rv.delay)) : -1;
      rv.flushDone = (rv.flushAt < 0) && ($urandom_range(0, 5) == 0);
      rv.expWb     = (rv.flushAt < 0) && !rv.flushDone;
      rv.expData   = rv32m(rv.op, rv.rs1, rv.rs2);
      rv.expBusy   = (rv.flushAt >= 0) ? rv.flushAt + 1 : rv.delay + 1;
      rv.expTimeout = 1'b0;
      applyStimulus(rv);
    end

`ifdef M_FASTPATH_EN
    applyFast(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
    applyFast(3'd6, 32'd5, 32'd0, 5'd11, 32'd5);
    applyFast(3'd5, 32'd9, 32'd0, 5'd17, 32'hFFFF_FFFF);
    applyFast(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/m_issue_ctrl.md
Name: m_issue_ctrl

Overview:
- Pipeline-side initiator for the RV32M multiply/divide unit.
- Accepts one M-extension instruction from the execute stage and stalls the pipeline.
- Drives the unit's START/M_CNT/RS1/RS2 request and holds it stable until READY.
- Captures the result and presents it to writeback as a one-cycle tagged pulse; supports flush and a busy watchdog.

Parameters:
- XLEN, 32, operand/result width
- RD_W, 5, destination register tag width
- TIMEOUT_CYCLES, 64, BUSY cycles before watchdog error (>=2)
- CNT_W, 16, width of the stall-cycle performance counter (saturating)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- EX_VALID  in  1  execute stage holds a valid instruction
- EX_IS_M  in  1  instruction is RV32M
- EX_M_CNT  in  3  funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- EX_RS1  in  XLEN  operand 1
- EX_RS2  in  XLEN  operand 2
- EX_RD  in  RD_W  destination tag
- FLUSH  in  1  kill in-flight M instruction
- STALL_PIPE  out  1  freeze pipeline (combinational)
- M_START  out  1  request to M unit (registered)
- M_CNT  out  3  op to M unit (registered)
- M_RS1  out  XLEN  operand to M unit (registered)
- M_RS2  out  XLEN  operand to M unit (registered)
- M_OUT  in  XLEN  result from M unit
- M_READY  in  1  M unit result valid
- WB_VALID  out  1  one-cycle result strobe
- WB_RD  out  RD_W  result tag
- WB_DATA  out  XLEN  result
- M_ERR  out  1  sticky watchdog error
- STALL_CNT  out  CNT_W  cycles spent in BUSY (saturating)

Behaviour:
Reset:
- Asynchronous, active-low; state IDLE.
- All registered outputs 0: M_START, M_CNT, M_RS1, M_RS2, WB_*, M_ERR, STALL_CNT, timer.

States (IDLE, BUSY, DONE):
- IDLE: req = EX_VALID & EX_IS_M & !FLUSH.
  - On req: latch EX_M_CNT/RS1/RS2/RD into M_* and tag reg, M_START<=1, timer<=0, go BUSY.
- BUSY: M_START, M_CNT, M_RS1, M_RS2 held constant every cycle (the unit restarts on any change).
  - M_READY==1: WB_DATA<=M_OUT, WB_RD<=tag, M_START<=0, go DONE.
  - FLUSH==1 (priority over M_READY): M_START<=0, go IDLE, no writeback.
  - Otherwise timer++; timer==TIMEOUT_CYCLES-1 and no M_READY: M_ERR<=1, M_START<=0, WB_DATA<=0, go DONE (frees pipeline).
  - STALL_CNT increments each BUSY cycle, saturates at all-ones.
- DONE: WB_VALID=1 for exactly this cycle; STALL_PIPE=0 so the instruction retires at this edge; no new request accepted; go IDLE. FLUSH in DONE suppresses WB_VALID.

Outputs:
- STALL_PIPE = (IDLE & req) | BUSY.
- WB_VALID is 0 outside DONE; WB_RD/WB_DATA hold last values.

Latency:
- Request seen at edge T.
- M_START high from T+1.
- WB_VALID one cycle after the cycle M_READY is sampled high.

Back-to-back: a second M instruction is issued from IDLE no earlier than one cycle after DONE; M_START is low for at least one cycle between ops.

M_ERR: cleared only by reset.

Optional Feature:
- Macro M_FASTPATH_EN.
- Defined, for div/divu/rem/remu with EX_RS2==0 or signed overflow (RS1=0x80000000, RS2=0xFFFFFFFF, ops 4/6), IDLE goes directly to DONE without asserting M_START:
  - div0: quotient 0xFFFFFFFF, remainder RS1.
  - overflow: div 0x80000000, rem 0.
  - WB_VALID at T+1; STALL_CNT unchanged.
- Undefined: all ops go through the M unit.

Test Plan:
- mul RS1=7, RS2=6, RD=3; M_READY asserted 4 cycles after M_START with M_OUT=42 -> M_* stable throughout, STALL_PIPE high, WB_VALID one cycle with WB_RD=3, WB_DATA=42, STALL_CNT=5.
- FLUSH in 2nd BUSY cycle of divu -> M_START low next cycle, state IDLE, no WB_VALID, STALL_PIPE low.
- M_READY never asserted -> after 64 BUSY cycles M_ERR=1, WB_VALID with WB_DATA=0, M_ERR stays 1 until RST_N low.
- Back-to-back mulh then mul, same operands -> M_START low one cycle between ops, two WB pulses, correct tags in order.
- RST_N low asynchronously mid-BUSY -> outputs 0 immediately, state IDLE.
- M_FASTPATH_EN: div 0x80000000/0xFFFFFFFF -> WB_DATA=0x80000000 at T+1, M_START never high. rem 5/0 -> WB_DATA=5.
